// File: rtl/dmem_responder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dmem_responder_pkg : FSM states and load/store size codes             |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
package dmem_responder_pkg;

   typedef enum logic [1:0] {
      DMEM_IDLE  = 2'd0,
      DMEM_ISSUE = 2'd1,
      DMEM_WAIT  = 2'd2,
      DMEM_RESP  = 2'd3
   } dmem_state_e;

   localparam logic [2:0] LD_LB  = 3'b000;
   localparam logic [2:0] LD_LH  = 3'b001;
   localparam logic [2:0] LD_LW  = 3'b010;
   localparam logic [2:0] LD_LBU = 3'b100;
   localparam logic [2:0] LD_LHU = 3'b101;

   localparam logic [1:0] ST_SB = 2'b00;
   localparam logic [1:0] ST_SH = 2'b01;
   localparam logic [1:0] ST_SW = 2'b10;

endpackage
`default_nettype wire

// File: rtl/dmem_align.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dmem_align : byte-lane mask, lane replication, misalign check and     |
// | load extract/extend (purely combinational)          rev 1.0           |
// +----------------------------------------------------------------------+
module dmem_align
   import dmem_responder_pkg::*;
(
   input  logic        we,
   input  logic [1:0]  offset,
   input  logic [1:0]  st_size,
   input  logic [2:0]  ld_size,
   input  logic [31:0] st_data,
   input  logic [31:0] ld_word,
   output logic [3:0]  wmask,
   output logic [31:0] wdata,
   output logic        err,
   output logic [31:0] ld_data
);

   logic [31:0] shifted;

   always_comb begin
      err     = 1'b0;
      wmask   = 4'b0000;
      wdata   = 32'h0;
      ld_data = 32'h0;
      shifted = ld_word >> {offset, 3'b000};

      if (we) begin
         case (st_size)
            ST_SB: begin
               wmask = 4'b0001 << offset;
               wdata = {4{st_data[7:0]}};
            end
            ST_SH: begin
               err   = offset[0];
               wmask = 4'b0011 << {offset[1], 1'b0};
               wdata = {2{st_data[15:0]}};
            end
            ST_SW: begin
               err   = |offset;
               wmask = 4'b1111;
               wdata = st_data;
            end
            default: err = 1'b1;
         endcase
      end else begin
         case (ld_size)
            LD_LB:  ld_data = {{24{shifted[7]}}, shifted[7:0]};
            LD_LBU: ld_data = {24'h0, shifted[7:0]};
            LD_LH: begin
               err     = offset[0];
               ld_data = {{16{shifted[15]}}, shifted[15:0]};
            end
            LD_LHU: begin
               err     = offset[0];
               ld_data = {16'h0, shifted[15:0]};
            end
            LD_LW: begin
               err     = |offset;
               ld_data = shifted;
            end
            default: err = 1'b1;
         endcase
      end

      // A rejected op never reaches memory, so keep its lane outputs quiet.
      if (err) begin
         wmask = 4'b0000;
         wdata = 32'h0;
      end
   end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dmem_responder : single-outstanding load/store responder driving a    |
// | valid/ready word-addressed memory port                rev 1.0         |
// +----------------------------------------------------------------------+
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [1:0]        st_size,
   input  logic [2:0]        ld_size,
   output logic              stall,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [3:0]        mem_wmask,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_resp_valid,
   input  logic [DATA_W-1:0] mem_resp_data
);

   dmem_state_e       state_q, state_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [2:0]        ld_size_q, ld_size_d;
   logic [3:0]        wmask_q, wmask_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              err_q, err_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;

   logic              is_idle;
   logic              al_we;
   logic [1:0]        al_offset;
   logic [2:0]        al_ld_size;
   logic [3:0]        al_wmask;
   logic [DATA_W-1:0] al_wdata;
   logic              al_err;
   logic [DATA_W-1:0] al_ld_data;

   // The aligner checks the incoming request in IDLE and extracts load data
   // from the latched request afterwards.
   assign is_idle    = (state_q == DMEM_IDLE);
   assign al_we      = is_idle ? req_we : we_q;
   assign al_offset  = is_idle ? req_addr[1:0] : addr_q[1:0];
   assign al_ld_size = is_idle ? ld_size : ld_size_q;

   dmem_align u_align (
      .we      (al_we),
      .offset  (al_offset),
      .st_size (st_size),
      .ld_size (al_ld_size),
      .st_data (req_wdata),
      .ld_word (mem_resp_data),
      .wmask   (al_wmask),
      .wdata   (al_wdata),
      .err     (al_err),
      .ld_data (al_ld_data)
   );

   always_comb begin
      state_d   = state_q;
      we_d      = we_q;
      addr_d    = addr_q;
      ld_size_d = ld_size_q;
      wmask_d   = wmask_q;
      wdata_d   = wdata_q;
      err_d     = err_q;
      rdata_d   = rdata_q;

      case (state_q)
         DMEM_IDLE: begin
            if (req_valid) begin
               we_d      = req_we;
               addr_d    = req_addr;
               ld_size_d = ld_size;
               wmask_d   = al_wmask;
               wdata_d   = al_wdata;
               err_d     = al_err;
               rdata_d   = '0;
               state_d   = al_err ? DMEM_RESP : DMEM_ISSUE;
            end
         end
         DMEM_ISSUE: begin
            if (mem_req_ready) begin
               state_d = we_q ? DMEM_RESP : DMEM_WAIT;
            end
         end
         DMEM_WAIT: begin
            if (mem_resp_valid) begin
               rdata_d = al_ld_data;
               state_d = DMEM_RESP;
            end
         end
         DMEM_RESP: state_d = DMEM_IDLE;
         default:   state_d = DMEM_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= DMEM_IDLE;
         we_q      <= 1'b0;
         addr_q    <= '0;
         ld_size_q <= 3'b000;
         wmask_q   <= 4'b0000;
         wdata_q   <= '0;
         err_q     <= 1'b0;
         rdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         ld_size_q <= ld_size_d;
         wmask_q   <= wmask_d;
         wdata_q   <= wdata_d;
         err_q     <= err_d;
         rdata_q   <= rdata_d;
      end
   end

   assign stall         = reset & ((is_idle & req_valid) ||
                                   (state_q == DMEM_ISSUE) ||
                                   (state_q == DMEM_WAIT));
   assign resp_valid    = (state_q == DMEM_RESP);
   assign resp_err      = resp_valid & err_q;
   assign resp_rdata    = resp_valid ? rdata_q : '0;
   assign mem_req_valid = (state_q == DMEM_ISSUE);
   assign mem_we        = we_q;
   assign mem_addr      = {addr_q[ADDR_W-1:2], 2'b00};
   assign mem_wmask     = wmask_q;
   assign mem_wdata     = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_dmem_responder : directed self-checking bench for dmem_responder   |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_we;
   logic [31:0] req_addr, req_wdata;
   logic [1:0]  st_size;
   logic [2:0]  ld_size;
   logic        stall, resp_valid, resp_err;
   logic [31:0] resp_rdata;
   logic        mem_req_valid, mem_req_ready, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_wmask;
   logic        mem_resp_valid;
   logic [31:0] mem_resp_data;

   int n_cmp = 0;
   int n_err = 0;

   dmem_responder #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk            (clk),
      .reset          (reset),
      .req_valid      (req_valid),
      .req_we         (req_we),
      .req_addr       (req_addr),
      .req_wdata      (req_wdata),
      .st_size        (st_size),
      .ld_size        (ld_size),
      .stall          (stall),
      .resp_valid     (resp_valid),
      .resp_rdata     (resp_rdata),
      .resp_err       (resp_err),
      .mem_req_valid  (mem_req_valid),
      .mem_req_ready  (mem_req_ready),
      .mem_we         (mem_we),
      .mem_addr       (mem_addr),
      .mem_wmask      (mem_wmask),
      .mem_wdata      (mem_wdata),
      .mem_resp_valid (mem_resp_valid),
      .mem_resp_data  (mem_resp_data)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
      end
   endtask

   // One complete operation: accept, optional issue/wait phases, response.
   task automatic run_op(input string tag, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [1:0] st, input logic [2:0] ld,
                         input int rdy_dly, input logic [31:0] mdata, input logic exp_err,
                         input logic [31:0] exp_addr, input logic [3:0] exp_mask,
                         input logic [31:0] exp_wdata, input logic [31:0] exp_rdata);
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
      st_size = st; ld_size = ld;
      #1 check({tag, " accept stall"}, {31'h0, stall}, 32'd1);
      @(negedge clk);
      req_valid = 1'b0;
      if (!exp_err) begin
         for (int i = 0; i <= rdy_dly; i++) begin
            #1;
            check({tag, " mreq_valid"}, {31'h0, mem_req_valid}, 32'd1);
            check({tag, " mem_we"}, {31'h0, mem_we}, {31'h0, we});
            check({tag, " mem_addr"}, mem_addr, exp_addr);
            check({tag, " mem_wmask"}, {28'h0, mem_wmask}, {28'h0, exp_mask});
            check({tag, " mem_wdata"}, mem_wdata, exp_wdata);
            check({tag, " issue stall"}, {31'h0, stall}, 32'd1);
            mem_req_ready = (i == rdy_dly);
            @(negedge clk);
            mem_req_ready = 1'b0;
         end
         if (!we) begin
            #1;
            check({tag, " wait mreq_valid"}, {31'h0, mem_req_valid}, 32'd0);
            check({tag, " wait stall"}, {31'h0, stall}, 32'd1);
            @(negedge clk);
            mem_resp_valid = 1'b1; mem_resp_data = mdata;
            @(negedge clk);
            mem_resp_valid = 1'b0; mem_resp_data = 32'h0;
         end
      end else begin
         #1 check({tag, " err no mreq"}, {31'h0, mem_req_valid}, 32'd0);
      end
      #1;
      check({tag, " resp_valid"}, {31'h0, resp_valid}, 32'd1);
      check({tag, " resp_err"}, {31'h0, resp_err}, {31'h0, exp_err});
      check({tag, " resp_rdata"}, resp_rdata, exp_rdata);
      check({tag, " resp stall"}, {31'h0, stall}, 32'd0);
      @(negedge clk);
      #1 check({tag, " resp pulse"}, {31'h0, resp_valid}, 32'd0);
   endtask

   initial begin
      reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
      st_size = 2'b00; ld_size = 3'b000; mem_req_ready = 1'b0;
      mem_resp_valid = 1'b0; mem_resp_data = 32'h0;
      repeat (3) @(negedge clk);
      #1;
      check("rst stall", {31'h0, stall}, 32'd0);
      check("rst resp_valid", {31'h0, resp_valid}, 32'd0);
      check("rst mreq_valid", {31'h0, mem_req_valid}, 32'd0);
      check("rst mem_addr", mem_addr, 32'h0);
      check("rst mem_wmask", {28'h0, mem_wmask}, 32'h0);
      reset = 1'b1;

      //     tag    we   addr          wdata         st     ld      rdy mdata         err   maddr         mask     mwdata        rdata
      run_op("SW",  1'b1, 32'h0000_0104, 32'hDEADBEEF, 2'b10, 3'b000, 3, 32'h0,        1'b0, 32'h0000_0104, 4'b1111, 32'hDEADBEEF, 32'h0);
      run_op("SB",  1'b1, 32'h0000_0103, 32'h0000_00A5, 2'b00, 3'b000, 0, 32'h0,       1'b0, 32'h0000_0100, 4'b1000, 32'hA5A5A5A5, 32'h0);
      run_op("SH",  1'b1, 32'h0000_0302, 32'h1234_ABCD, 2'b01, 3'b000, 1, 32'h0,       1'b0, 32'h0000_0300, 4'b1100, 32'hABCDABCD, 32'h0);
      run_op("LB",  1'b0, 32'h0000_0202, 32'h0,        2'b00, 3'b000, 0, 32'h0080_0000, 1'b0, 32'h0000_0200, 4'b0000, 32'h0,        32'hFFFFFF80);
      run_op("LBU", 1'b0, 32'h0000_0202, 32'h0,        2'b00, 3'b100, 0, 32'h0080_0000, 1'b0, 32'h0000_0200, 4'b0000, 32'h0,        32'h0000_0080);
      run_op("LHU", 1'b0, 32'h0000_0202, 32'h0,        2'b00, 3'b101, 2, 32'h8001_0000, 1'b0, 32'h0000_0200, 4'b0000, 32'h0,        32'h0000_8001);
      run_op("LH",  1'b0, 32'h0000_0202, 32'h0,        2'b00, 3'b001, 0, 32'h8001_0000, 1'b0, 32'h0000_0200, 4'b0000, 32'h0,        32'hFFFF_8001);
      run_op("LW",  1'b0, 32'h0000_0300, 32'h0,        2'b00, 3'b010, 0, 32'h1234_5678, 1'b0, 32'h0000_0300, 4'b0000, 32'h0,        32'h1234_5678);
      run_op("LWmis", 1'b0, 32'h0000_0302, 32'h0,      2'b00, 3'b010, 0, 32'h0,        1'b1, 32'h0,        4'b0000, 32'h0,        32'h0);
      run_op("SHmis", 1'b1, 32'h0000_0301, 32'hFFFF_FFFF, 2'b01, 3'b000, 0, 32'h0,     1'b1, 32'h0,        4'b0000, 32'h0,        32'h0);
      run_op("LD011", 1'b0, 32'h0000_0300, 32'h0,      2'b00, 3'b011, 0, 32'h0,        1'b1, 32'h0,        4'b0000, 32'h0,        32'h0);

      // Reset while a load waits for data; the late return must be dropped.
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_0400; ld_size = 3'b010;
      @(negedge clk);
      req_valid = 1'b0; mem_req_ready = 1'b1;
      #1 check("rstmid issue", {31'h0, mem_req_valid}, 32'd1);
      @(negedge clk);
      mem_req_ready = 1'b0;
      #1 check("rstmid wait stall", {31'h0, stall}, 32'd1);
      reset = 1'b0;
      @(negedge clk);
      #1;
      check("rstmid stall", {31'h0, stall}, 32'd0);
      check("rstmid mreq_valid", {31'h0, mem_req_valid}, 32'd0);
      check("rstmid mem_addr", mem_addr, 32'h0);
      reset = 1'b1; mem_resp_valid = 1'b1; mem_resp_data = 32'h5555_AAAA;
      @(negedge clk);
      mem_resp_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1 check("rstmid no resp", {31'h0, resp_valid}, 32'd0);
         check("rstmid no stall", {31'h0, stall}, 32'd0);
         @(negedge clk);
      end

      // Back-to-back SW then LW with req_valid held high through RESP.
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0000_0600; req_wdata = 32'h0BAD_F00D;
      st_size = 2'b10;
      #1 check("b2b sw stall", {31'h0, stall}, 32'd1);
      @(negedge clk);
      mem_req_ready = 1'b1;
      #1 check("b2b sw issue", {31'h0, mem_req_valid & mem_we}, 32'd1);
      @(negedge clk);
      mem_req_ready = 1'b0;
      #1 check("b2b sw resp", {31'h0, resp_valid}, 32'd1);
      check("b2b resp stall", {31'h0, stall}, 32'd0);
      @(negedge clk);
      req_we = 1'b0; req_addr = 32'h0000_0500; ld_size = 3'b010;
      #1 check("b2b idle resp", {31'h0, resp_valid}, 32'd0);
      check("b2b lw stall", {31'h0, stall}, 32'd1);
      check("b2b no reissue", {31'h0, mem_req_valid}, 32'd0);
      @(negedge clk);
      #1 check("b2b lw issue", {31'h0, mem_req_valid}, 32'd1);
      check("b2b lw we", {31'h0, mem_we}, 32'd0);
      check("b2b lw addr", mem_addr, 32'h0000_0500);
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 32'hCAFE_F00D;
      #1 check("b2b lw wait", {31'h0, resp_valid}, 32'd0);
      @(negedge clk);
      mem_resp_valid = 1'b0;
      #1 check("b2b lw resp", {31'h0, resp_valid}, 32'd1);
      check("b2b lw rdata", resp_rdata, 32'hCAFE_F00D);
      req_valid = 1'b0;
      @(negedge clk);
      #1 check("b2b lw single", {31'h0, resp_valid}, 32'd0);
      check("b2b lw idle", {31'h0, mem_req_valid}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
